spi_sram_host: RTL and testbench
================================

# spi_sram_host

SPI initiator that drives the four-wire SPI link into `spi_external_sram` (`spi_cs_n`, `spi_clk`, `spi_din`, `spi_dout`). It converts single-word requests into SPI frames: SRAM0/SRAM1 byte reads and writes, and 32-bit GPIO register reads and writes. It sits in the host-side FPGA and in the board-level bench, and is the counterpart that loads training data and pokes the `gpio_output0` control word.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period. Legal range 4..255.
- `GAP_CYC`, default 8: minimum `clk` cycles that `spi_cs_n` stays high between frames.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: the host can accept a request.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_target`, in, 2: 00 = SRAM0, 01 = SRAM1, 10 = GPIO, 11 = reserved (treated as GPIO).
- `req_addr`, in, 24: SRAM byte address (bits [16:0] used), or GPIO index (bits [2:0] used).
- `req_wdata`, in, 32: write data; SRAM targets use bits [7:0].
- `rsp_valid`, out, 1: one-cycle completion pulse, issued for reads and for writes.
- `rsp_rdata`, out, 32: read data. SRAM reads are zero-extended. Holds its value until the next read completes.
- `busy`, out, 1: high from request accept until the gap ends.
- `spi_cs_n`, out, 1: chip select, active low.
- `spi_clk`, out, 1: SPI clock, mode 0 (idles low).
- `spi_din`, out, 1: MOSI.
- `spi_dout`, in, 1: MISO, asynchronous to `clk`.

## Operation
**Request accept**
- A request is accepted on a `clk` edge with `req_valid && req_ready`.
- All request fields are latched at accept.

**Frame format** (MSB first, every field):
- Command byte `{req_write, req_target, 5'b0}`.
- 24-bit address.
- Read only: one dummy byte of zeros (see Configuration).
- Data field: 8 bits for SRAM, 32 bits for GPIO.
- Total length N bits: SRAM write 40, SRAM read 48, GPIO write 64, GPIO read 72.
- For reads, MOSI is 0 during the data phase.

**State machine**: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: `req_ready` = 1.
- SETUP: `spi_cs_n` = 0, `spi_clk` = 0, `spi_din` = bit N-1. Lasts CLK_DIV cycles.
- SHIFT: each bit is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles. `spi_din` changes only on the `clk` edge where `spi_clk` falls.
- HOLD: CLK_DIV cycles after the last low phase, with `spi_cs_n` still low.
- GAP: `spi_cs_n` = 1 for GAP_CYC cycles, with `req_ready` = 0.

**MISO capture**
- `spi_dout` passes through a 2-flop synchronizer.
- Each bit is captured on the last `clk` cycle of its high phase.
- Only data-phase bits shift into the read register.
- `rsp_rdata` updates in the same cycle `rsp_valid` is asserted.

**Counters**
- An 8-bit bit counter counts down from N-1.
- An 8-bit divider counter counts from CLK_DIV-1 down to 0.
- Both counters wrap only through reload; there is no free-running wrap.

## Timing
**Reset values**
- `spi_cs_n` = 1, `spi_clk` = 0, `spi_din` = 0.
- `req_ready` = 1 (while `rst_n` = 1 and in IDLE), `rsp_valid` = 0, `rsp_rdata` = 0, `busy` = 0.

**Latency**
- The accept edge is cycle 0.
- `spi_cs_n` falls in cycle 1.
- `spi_cs_n` rises and `rsp_valid` pulses in cycle 2·CLK_DIV·(N+1)+1.
- `req_ready` returns GAP_CYC cycles after that.

**Boundary behaviour**
- Request held during busy: `req_valid` with `req_ready` = 0 is ignored. The requester must hold the request; no queueing.
- Back-to-back requests: a request already presented when IDLE is entered is accepted on the first IDLE cycle.
- Reset mid-frame:
  - `rst_n` low immediately forces the outputs to their reset values.
  - `spi_cs_n` high aborts the frame at the target.
  - No `rsp_valid` is issued for the aborted frame.
- Reserved target 11 is encoded unchanged in the command byte. Its length is the GPIO length.
- `req_wdata` and `req_addr` changing after accept have no effect.

## Configuration
- `SPI_SRAM_HOST_DUMMY_EN` defined:
  - Reads insert one dummy byte between address and data.
  - SRAM read N = 48, GPIO read N = 72.
- `SPI_SRAM_HOST_DUMMY_EN` undefined:
  - Data follows the address directly.
  - SRAM read N = 40, GPIO read N = 64.
- Writes are identical in both builds.

## Test plan
All tests use CLK_DIV=4 and GAP_CYC=8, with the reference target model on the bus.

- SRAM0 write, addr 0x00012A, wdata 0x5C -> MOSI carries 0x80, 0x00012A, 0x5C. `spi_cs_n` is low for cycles 1..328. `rsp_valid` pulses at cycle 329, and the target SRAM0[0x12A] = 0x5C.
- SRAM1 read, addr 0x01FFFF, model returns 0xA5 (DUMMY_EN defined) -> command 0x20. `rsp_valid` pulses at cycle 393 with `rsp_rdata` = 0x000000A5.
- GPIO write, index 0, wdata 0x00000010 -> 64-bit frame. The target `gpio_output0` = 0x10 after `spi_cs_n` rises, and `rsp_valid` pulses at cycle 521.
- GPIO read, index 1, model drives 0xDEADBEEF -> `rsp_rdata` = 0xDEADBEEF. Repeat with DUMMY_EN undefined -> `rsp_valid` pulses at cycle 521.
- Back-to-back: two SRAM writes with `req_valid` held high -> the second accept occurs exactly 8 cycles after the first `rsp_valid`. `spi_cs_n` is high for 8 or more cycles between frames.
- Reset mid-frame: `rst_n` is pulled low at cycle 100 of a GPIO write -> in the same cycle `spi_cs_n` = 1 and `spi_clk` = 0. No `rsp_valid` is issued, and after release `req_ready` = 1.

Source files
------------

// File: rtl/spi_sram_host.sv
// SPI initiator for spi_external_sram: one request -> one framed SRAM byte or GPIO word access.
// Build option: define SPI_SRAM_HOST_DUMMY_EN to insert a dummy byte between address and read data.
module spi_sram_host #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_target,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_din,
    input  logic        spi_dout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

`ifdef SPI_SRAM_HOST_DUMMY_EN
    localparam int RD_PAD = 8;
`else
    localparam int RD_PAD = 0;
`endif

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [7:0]  bit_cnt;
    logic        ph_low;
    logic [71:0] sreg;
    logic        wr_q;
    logic        gpio_q;
    logic [31:0] rd_sh;
    logic [1:0]  miso_sync;

    logic        accept;
    logic        div_done;
    logic        active;
    logic [7:0]  frame_len;
    logic [31:0] wdata_field;
    logic [71:0] frame;
    logic [7:0]  data_bits;

    assign accept    = req_valid && req_ready && (state == S_IDLE);
    assign div_done  = (div_cnt == 8'd0);
    assign active    = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
    assign data_bits = gpio_q ? 8'd32 : 8'd8;
    assign busy      = ~req_ready;

    // Target 11 shares the GPIO length; the command byte carries the target as given.
    always_comb begin
        frame_len = 8'd40;
        if (req_target[1])
            frame_len = req_write ? 8'd64 : 8'(64 + RD_PAD);
        else
            frame_len = req_write ? 8'd40 : 8'(40 + RD_PAD);
    end

    always_comb begin
        wdata_field = 32'd0;
        if (req_write)
            wdata_field = req_target[1] ? req_wdata : {req_wdata[7:0], 24'd0};
        frame = {req_write, req_target, 5'd0, req_addr, wdata_field, 8'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) miso_sync <= 2'b00;
        else        miso_sync <= {miso_sync[0], spi_dout};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 8'd0;
            ph_low  <= 1'b0;
            sreg    <= 72'd0;
            wr_q    <= 1'b0;
            gpio_q  <= 1'b0;
            rd_sh   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state   <= S_SETUP;
                    div_cnt <= DIV_LOAD;
                    bit_cnt <= frame_len - 8'd1;
                    ph_low  <= 1'b0;
                    sreg    <= frame;
                    wr_q    <= req_write;
                    gpio_q  <= req_target[1];
                    rd_sh   <= 32'd0;
                end
                S_SETUP: begin
                    if (div_done) begin
                        state   <= S_SHIFT;
                        div_cnt <= DIV_LOAD;
                    end else div_cnt <= div_cnt - 8'd1;
                end
                S_SHIFT: begin
                    if (!div_done) div_cnt <= div_cnt - 8'd1;
                    else begin
                        div_cnt <= DIV_LOAD;
                        // End of high phase: sample MISO, advance MOSI on the falling edge.
                        if (!ph_low) begin
                            ph_low <= 1'b1;
                            sreg   <= {sreg[70:0], 1'b0};
                            if (!wr_q && (bit_cnt < data_bits))
                                rd_sh <= {rd_sh[30:0], miso_sync[1]};
                        end else begin
                            ph_low <= 1'b0;
                            if (bit_cnt == 8'd0) state <= S_HOLD;
                            else                 bit_cnt <= bit_cnt - 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (div_done) begin
                        state   <= S_GAP;
                        div_cnt <= GAP_LOAD;
                    end else div_cnt <= div_cnt - 8'd1;
                end
                S_GAP: begin
                    if (div_done) state <= S_IDLE;
                    else          div_cnt <= div_cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pin-side registers trail the FSM by one cycle so every SPI output is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_cs_n  <= 1'b1;
            spi_clk   <= 1'b0;
            spi_din   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            req_ready <= 1'b1;
        end else begin
            spi_cs_n  <= ~active;
            spi_clk   <= (state == S_SHIFT) && !ph_low;
            spi_din   <= active && sreg[71];
            rsp_valid <= (state == S_GAP) && (div_cnt == GAP_LOAD);
            if ((state == S_GAP) && (div_cnt == GAP_LOAD) && !wr_q)
                rsp_rdata <= rd_sh;
            req_ready <= (state == S_IDLE) && !accept;
        end
    end

endmodule

// File: tb/tb_spi_sram_host.sv
// Directed bench for spi_sram_host with a cycle-sampled SPI target model on the bus.
module tb_spi_sram_host;

`ifdef SPI_SRAM_HOST_DUMMY_EN
    localparam int PAD = 8;
`else
    localparam int PAD = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_target;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_din;
    logic        spi_dout;

    spi_sram_host #(.CLK_DIV(4), .GAP_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_din(spi_din), .spi_dout(spi_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target model: records MOSI on spi_clk rises, shifts MISO out on spi_clk falls.
    logic [71:0] mosi_sh;
    int          mosi_n;
    logic [31:0] miso_word;
    int          miso_hdr;
    int          miso_dw;
    logic        clk_q = 1'b0;
    logic        cs_q  = 1'b1;

    initial spi_dout = 1'b0;

    always @(posedge clk) begin
        clk_q <= spi_clk;
        cs_q  <= spi_cs_n;
        if (cs_q && !spi_cs_n) begin
            mosi_n   <= 0;
            mosi_sh  <= '0;
            spi_dout <= 1'b0;
        end else if (!spi_cs_n && spi_clk && !clk_q) begin
            mosi_sh <= {mosi_sh[70:0], spi_din};
            mosi_n  <= mosi_n + 1;
        end else if (!spi_cs_n && !spi_clk && clk_q) begin
            if (mosi_n >= miso_hdr && mosi_n < miso_hdr + miso_dw)
                spi_dout <= miso_word[miso_dw - 1 - (mosi_n - miso_hdr)];
            else
                spi_dout <= 1'b0;
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  tgt;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] miso;
        int          n;
        logic [71:0] frame;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int bad   = 0;

    int          r_cs_fall, r_rsp, r_rdy, r_rsp_cnt, r_cs_low;
    logic [31:0] r_rd;
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [1:0] tgt, input logic [23:0] addr,
                           input logic [31:0] wd);
        r_cs_fall = -1; r_rsp = -1; r_rdy = -1; r_rsp_cnt = 0; r_cs_low = 0; r_rd = '0;
        @(negedge clk);
        req_write = wr; req_target = tgt; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        chk("ready_pre", {71'd0, req_ready}, 72'd1);
        @(posedge clk); #1;
        // Scramble the request after accept; the frame must not notice.
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_write = ~wr; req_target = ~tgt;
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk); #1;
            if (!spi_cs_n) begin
                r_cs_low++;
                if (r_cs_fall < 0) r_cs_fall = k;
            end
            if (rsp_valid) begin
                r_rsp_cnt++;
                if (r_rsp < 0) begin r_rsp = k; r_rd = rsp_rdata; end
            end
            if (req_ready) begin r_rdy = k; break; end
        end
    endtask

    initial begin
        int n;
        logic [71:0] ef;
        logic [31:0] exp_rd;
        int acc2, rsp1, rsp2, gap_hi, rsp_seen, cs_hi, falls;

        vecs[0] = '{1'b1, 2'b00, 24'h00012A, 32'h0000005C, 32'h0,        40, 72'h80_00012A_5C};
        vecs[1] = '{1'b0, 2'b01, 24'h01FFFF, 32'h0,        32'hA5,       40, 72'h20_01FFFF_00};
        vecs[2] = '{1'b1, 2'b10, 24'h000000, 32'h00000010, 32'h0,        64, 72'hC0_000000_00000010};
        vecs[3] = '{1'b0, 2'b10, 24'h000001, 32'h0,        32'hDEADBEEF, 64, 72'h40_000001_00000000};
        vecs[4] = '{1'b1, 2'b11, 24'h000002, 32'hCAFEF00D, 32'h0,        64, 72'hE0_000002_CAFEF00D};
        vecs[5] = '{1'b1, 2'b01, 24'h01FFFF, 32'h123456FF, 32'h0,        40, 72'hA0_01FFFF_FF};
        vecs[6] = '{1'b0, 2'b00, 24'h000000, 32'h0,        32'h3C,       40, 72'h00_000000_00};
        vecs[7] = '{1'b0, 2'b11, 24'h000007, 32'h0,        32'h80000001, 64, 72'h60_000007_00000000};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_target = 2'b00;
        req_addr = '0; req_wdata = '0; miso_word = '0; miso_hdr = 0; miso_dw = 0;
        last_rd = 32'd0;
        #12;
        chk("rst_cs_n",  {71'd0, spi_cs_n},  72'd1);
        chk("rst_spi_clk", {71'd0, spi_clk}, 72'd0);
        chk("rst_din",   {71'd0, spi_din},   72'd0);
        chk("rst_rsp_valid", {71'd0, rsp_valid}, 72'd0);
        chk("rst_rdata", {40'd0, rsp_rdata}, 72'd0);
        chk("rst_busy",  {71'd0, busy},      72'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {71'd0, req_ready}, 72'd1);

        for (int i = 0; i < 8; i++) begin
            n  = vecs[i].n + (vecs[i].wr ? 0 : PAD);
            ef = vecs[i].wr ? vecs[i].frame : (vecs[i].frame << PAD);
            miso_word = vecs[i].miso;
            miso_dw   = vecs[i].tgt[1] ? 32 : 8;
            miso_hdr  = n - miso_dw;
            exp_rd    = vecs[i].wr ? last_rd : vecs[i].miso;
            run_req(vecs[i].wr, vecs[i].tgt, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_cs_fall", i), 72'(r_cs_fall), 72'd1);
            chk($sformatf("v%0d_cs_low", i),  72'(r_cs_low),  72'(8 * n + 8));
            chk($sformatf("v%0d_rsp_at", i),  72'(r_rsp),     72'(8 * n + 9));
            chk($sformatf("v%0d_rsp_cnt", i), 72'(r_rsp_cnt), 72'd1);
            chk($sformatf("v%0d_ready_at", i), 72'(r_rdy),    72'(8 * n + 17));
            chk($sformatf("v%0d_bits", i),    72'(mosi_n),    72'(n));
            chk($sformatf("v%0d_mosi", i),    mosi_sh,        ef);
            chk($sformatf("v%0d_rdata", i),   {40'd0, r_rd},  {40'd0, exp_rd});
            if (!vecs[i].wr) last_rd = vecs[i].miso;
        end

        // Back-to-back: req_valid held across the whole first frame and its gap.
        miso_word = '0; miso_hdr = 40; miso_dw = 8;
        @(negedge clk);
        req_write = 1'b1; req_target = 2'b00; req_addr = 24'h000005; req_wdata = 32'h11;
        req_valid = 1'b1;
        @(posedge clk); #1;
        acc2 = -1; rsp1 = -1; rsp2 = -1; gap_hi = 0; rsp_seen = 0; cs_hi = 0; falls = 0;
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk); #1;
            if (req_ready && acc2 < 0) acc2 = k;
            if (rsp_valid) begin
                rsp_seen++;
                if (rsp1 < 0) rsp1 = k; else rsp2 = k;
            end
            if (rsp1 >= 0 && rsp2 < 0 && falls == 0) begin
                if (spi_cs_n) cs_hi++;
                else begin gap_hi = cs_hi; falls = 1; end
            end
            if (rsp2 >= 0) break;
        end
        req_valid = 1'b0;
        chk("b2b_rsp1",        72'(rsp1),        72'd329);
        chk("b2b_accept_gap",  72'(acc2 - rsp1), 72'd8);
        chk("b2b_cs_high_ge8", {71'd0, gap_hi >= 8}, 72'd1);
        chk("b2b_rsp2",        72'(rsp2),        72'(338 + 329));
        chk("b2b_rsp_count",   72'(rsp_seen),    72'd2);
        for (int k = 0; k < 200 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("b2b_idle", {71'd0, req_ready}, 72'd1);

        // Reset at cycle 100 of a GPIO write.
        @(negedge clk);
        req_write = 1'b1; req_target = 2'b10; req_addr = 24'h0; req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_cs_before", {71'd0, spi_cs_n}, 72'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_cs_n",  {71'd0, spi_cs_n},  72'd1);
        chk("mid_spi_clk", {71'd0, spi_clk}, 72'd0);
        chk("mid_din",   {71'd0, spi_din},   72'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0; cs_hi = 0;
        for (int k = 0; k < 700; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
            if (!spi_cs_n) cs_hi++;
        end
        chk("mid_no_rsp",  72'(rsp_seen), 72'd0);
        chk("mid_cs_idle", 72'(cs_hi),    72'd0);
        chk("mid_ready",   {71'd0, req_ready}, 72'd1);
        chk("mid_busy",    {71'd0, busy},      72'd0);

        // Recovery: a plain SRAM read after the abort.
        miso_word = 32'h7E; miso_dw = 8; miso_hdr = 32 + PAD;
        run_req(1'b0, 2'b00, 24'h000ABC, 32'h0);
        chk("rec_rsp_at", 72'(r_rsp), 72'(8 * (40 + PAD) + 9));
        chk("rec_rdata",  {40'd0, r_rd}, 72'h7E);
        chk("rec_mosi",   mosi_sh, 72'h00_000ABC_00 << PAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
